// File: rtl/regfile_wb_arbiter.sv
// Shares the register file write port between primary writeback and a buffered
// long-latency unit, with a destination scoreboard for hazard detection.
module regfile_wb_arbiter #(
    parameter int DW    = 32,
    parameter int AW    = 5,
    parameter int DEPTH = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        p_we,
    input  logic [AW-1:0]               p_rd,
    input  logic [DW-1:0]               p_wd,
    output logic                        p_stall,
    input  logic                        s_issue,
    input  logic [AW-1:0]               s_issue_rd,
    input  logic                        s_valid,
    input  logic [AW-1:0]               s_rd,
    input  logic [DW-1:0]               s_wd,
    output logic                        s_ready,
    input  logic [AW-1:0]               q_a1,
    input  logic [AW-1:0]               q_a2,
    input  logic [AW-1:0]               q_rd,
    output logic                        hz_stall,
    output logic                        rf_we,
    output logic [AW-1:0]               rf_a3,
    output logic [DW-1:0]               rf_wd,
    output logic [(1<<AW)-1:0]          pending,
    output logic [$clog2(DEPTH):0]      fifo_cnt
);

    localparam int PW   = $clog2(DEPTH);
    localparam int CW   = PW + 1;
    localparam int NREG = 1 << AW;

    logic [AW-1:0]   rd_mem [DEPTH];
    logic [DW-1:0]   wd_mem [DEPTH];
    logic [PW-1:0]   wr_ptr_reg;
    logic [PW-1:0]   rd_ptr_reg;
    logic [CW-1:0]   cnt_reg;
    logic [NREG-1:0] pending_reg;
    logic [NREG-1:0] pending_next;
    logic [NREG-1:0] set_vec;
    logic [NREG-1:0] clr_vec;

    logic            full;
    logic            empty;
    logic            push;
    logic            pop;
    logic            p_act;
    logic            grant_p;
    logic            grant_fifo;
    logic [AW-1:0]   head_rd;
    logic [DW-1:0]   head_wd;

    assign full    = (cnt_reg == CW'(DEPTH));
    assign empty   = (cnt_reg == '0);
    assign head_rd = rd_mem[rd_ptr_reg];
    assign head_wd = wd_mem[rd_ptr_reg];

    // s_ready comes from registered occupancy only, so no path from s_valid.
    assign s_ready = rst && !full;
    assign push    = s_valid && s_ready;

    // Primary writes to x0 count as idle slots so they never block the drain.
    assign p_act      = p_we && (p_rd != '0);
    assign grant_fifo = rst && (full || (!p_act && !empty));
    assign grant_p    = rst && !full && p_act;
    assign pop        = grant_fifo;
    assign p_stall    = rst && full;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            cnt_reg    <= '0;
        end else begin
            if (push)
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            cnt_reg <= cnt_reg + CW'(push) - CW'(pop);
        end
    end

    // Storage needs no reset: occupancy alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            rd_mem[wr_ptr_reg] <= s_rd;
            wd_mem[wr_ptr_reg] <= s_wd;
        end
    end

    always_comb begin
        rf_we = 1'b0;
        rf_a3 = '0;
        rf_wd = '0;
        if (grant_p) begin
            rf_we = 1'b1;
            rf_a3 = p_rd;
            rf_wd = p_wd;
        end else if (grant_fifo) begin
            rf_we = (head_rd != '0);
            rf_a3 = head_rd;
            rf_wd = head_wd;
        end
    end

    // x0 never becomes pending, so its set/clear lines are tied off.
    assign set_vec[0] = 1'b0;
    assign clr_vec[0] = 1'b0;

    generate
        for (genvar gi = 1; gi < NREG; gi++) begin : g_sb
            assign set_vec[gi] = s_issue && (s_issue_rd == AW'(gi));
            assign clr_vec[gi] = pop && (head_rd == AW'(gi));
        end
    endgenerate

    // Set is applied after clear so a re-issue in the retiring cycle survives.
    assign pending_next = (pending_reg & ~clr_vec) | set_vec;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            pending_reg <= '0;
        else
            pending_reg <= pending_next;
    end

    assign pending  = pending_reg;
    assign fifo_cnt = cnt_reg;
    assign hz_stall = rst && (pending_reg[q_a1] | pending_reg[q_a2] | pending_reg[q_rd]);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: primary path, secondary drain,
// full-FIFO priority, scoreboard set/clear, x0 handling and mid-drain reset.
module tb_regfile_wb_arbiter;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 2;

    logic                    clk;
    logic                    rst;
    logic                    p_we;
    logic [AW-1:0]           p_rd;
    logic [DW-1:0]           p_wd;
    logic                    p_stall;
    logic                    s_issue;
    logic [AW-1:0]           s_issue_rd;
    logic                    s_valid;
    logic [AW-1:0]           s_rd;
    logic [DW-1:0]           s_wd;
    logic                    s_ready;
    logic [AW-1:0]           q_a1;
    logic [AW-1:0]           q_a2;
    logic [AW-1:0]           q_rd;
    logic                    hz_stall;
    logic                    rf_we;
    logic [AW-1:0]           rf_a3;
    logic [DW-1:0]           rf_wd;
    logic [(1<<AW)-1:0]      pending;
    logic [$clog2(DEPTH):0]  fifo_cnt;

    int n_total = 0;
    int n_bad   = 0;

    regfile_wb_arbiter #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .p_we       (p_we),
        .p_rd       (p_rd),
        .p_wd       (p_wd),
        .p_stall    (p_stall),
        .s_issue    (s_issue),
        .s_issue_rd (s_issue_rd),
        .s_valid    (s_valid),
        .s_rd       (s_rd),
        .s_wd       (s_wd),
        .s_ready    (s_ready),
        .q_a1       (q_a1),
        .q_a2       (q_a2),
        .q_rd       (q_rd),
        .hz_stall   (hz_stall),
        .rf_we      (rf_we),
        .rf_a3      (rf_a3),
        .rf_wd      (rf_wd),
        .pending    (pending),
        .fifo_cnt   (fifo_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    // Inputs change just after the falling edge; checks follow 1 ns later.
    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0;
        p_we = 1'b1; p_rd = 5'd3; p_wd = 32'h1;
        s_issue = 1'b0; s_issue_rd = '0;
        s_valid = 1'b0; s_rd = '0; s_wd = '0;
        q_a1 = '0; q_a2 = '0; q_rd = '0;

        // Held in reset with a live primary write request.
        tick(); #1;
        chk("rst_rf_we", rf_we, 0);
        chk("rst_p_stall", p_stall, 0);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_fifo_cnt", fifo_cnt, 0);
        chk("rst_pending", pending, 0);
        chk("rst_rf_a3", rf_a3, 0);

        // Primary-only traffic.
        tick();
        rst = 1'b1; p_we = 1'b1; p_rd = 5'd3; p_wd = 32'hDEADBEEF;
        #1;
        chk("pri_rf_we", rf_we, 1);
        chk("pri_rf_a3", rf_a3, 3);
        chk("pri_rf_wd", rf_wd, 32'hDEADBEEF);
        chk("pri_p_stall", p_stall, 0);
        chk("pri_s_ready", s_ready, 1);
        p_rd = 5'd0; #1;
        chk("pri_x0_rf_we", rf_we, 0);
        chk("pri_x0_rf_a3", rf_a3, 0);

        // Secondary drain with idle primary.
        tick();
        p_we = 1'b0; s_issue = 1'b1; s_issue_rd = 5'd9; q_a1 = 5'd9; #1;
        chk("iss9_hz_before_edge", hz_stall, 0);
        tick();
        s_issue = 1'b0; #1;
        chk("iss9_pending", pending, 32'h0000_0200);
        chk("iss9_hz_a1", hz_stall, 1);
        q_a1 = '0; q_rd = 5'd9; #1;
        chk("iss9_hz_rd", hz_stall, 1);
        q_rd = '0; #1;
        chk("iss9_hz_none", hz_stall, 0);
        s_valid = 1'b1; s_rd = 5'd9; s_wd = 32'h12; #1;
        chk("sec9_no_bypass", rf_we, 0);
        tick();
        s_valid = 1'b0; #1;
        chk("sec9_cnt", fifo_cnt, 1);
        chk("sec9_rf_we", rf_we, 1);
        chk("sec9_rf_a3", rf_a3, 9);
        chk("sec9_rf_wd", rf_wd, 32'h12);
        chk("sec9_pending_held", pending, 32'h0000_0200);
        tick(); #1;
        chk("sec9_cnt_after", fifo_cnt, 0);
        chk("sec9_pending_after", pending, 0);
        chk("sec9_rf_we_after", rf_we, 0);

        // Priority and full: primary held busy while two results arrive.
        tick();
        s_issue = 1'b1; s_issue_rd = 5'd5;
        tick();
        s_issue_rd = 5'd7;
        tick();
        s_issue = 1'b0;
        p_we = 1'b1; p_rd = 5'd3; p_wd = 32'h111;
        s_valid = 1'b1; s_rd = 5'd5; s_wd = 32'h55; #1;
        chk("full_pending57", pending, 32'h0000_00A0);
        chk("full_c0_rf_a3", rf_a3, 3);
        tick();
        s_rd = 5'd7; s_wd = 32'h77; #1;
        chk("full_c1_cnt", fifo_cnt, 1);
        chk("full_c1_rf_a3", rf_a3, 3);
        chk("full_c1_p_stall", p_stall, 0);
        tick();
        s_valid = 1'b0; #1;
        chk("full_c2_cnt", fifo_cnt, 2);
        chk("full_c2_s_ready", s_ready, 0);
        chk("full_c2_p_stall", p_stall, 1);
        chk("full_c2_rf_we", rf_we, 1);
        chk("full_c2_rf_a3", rf_a3, 5);
        chk("full_c2_rf_wd", rf_wd, 32'h55);
        tick(); #1;
        chk("full_c3_cnt", fifo_cnt, 1);
        chk("full_c3_p_stall", p_stall, 0);
        chk("full_c3_rf_a3", rf_a3, 3);
        chk("full_c3_rf_wd", rf_wd, 32'h111);
        chk("full_c3_pending", pending, 32'h0000_0080);
        p_we = 1'b0; #1;
        chk("full_c3_drain_a3", rf_a3, 7);
        chk("full_c3_drain_wd", rf_wd, 32'h77);
        tick(); #1;
        chk("full_c4_cnt", fifo_cnt, 0);
        chk("full_c4_pending", pending, 0);

        // Reset mid-drain with two results queued.
        s_issue = 1'b1; s_issue_rd = 5'd5;
        tick();
        s_issue_rd = 5'd7;
        tick();
        s_issue = 1'b0;
        p_we = 1'b1; p_rd = 5'd3; p_wd = 32'h222;
        s_valid = 1'b1; s_rd = 5'd5; s_wd = 32'h5A;
        tick();
        s_rd = 5'd7; s_wd = 32'h7A;
        tick();
        s_valid = 1'b0; #1;
        chk("mid_cnt", fifo_cnt, 2);
        chk("mid_pending", pending, 32'h0000_00A0);
        rst = 1'b0; #1;
        chk("mid_rst_cnt", fifo_cnt, 0);
        chk("mid_rst_pending", pending, 0);
        chk("mid_rst_rf_we", rf_we, 0);
        chk("mid_rst_p_stall", p_stall, 0);
        chk("mid_rst_s_ready", s_ready, 0);
        tick();
        rst = 1'b1; p_we = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("post_rst_rf_we_%0d", i), rf_we, 0);
            chk($sformatf("post_rst_cnt_%0d", i), fifo_cnt, 0);
            tick();
        end

        // Simultaneous set and clear of the same register.
        s_issue = 1'b1; s_issue_rd = 5'd4;
        tick();
        s_issue = 1'b0;
        s_valid = 1'b1; s_rd = 5'd4; s_wd = 32'h44;
        tick();
        s_valid = 1'b0;
        s_issue = 1'b1; s_issue_rd = 5'd4; #1;
        chk("sc_pop_a3", rf_a3, 4);
        tick();
        s_issue = 1'b0; #1;
        chk("sc_pending4_kept", pending, 32'h0000_0010);
        s_valid = 1'b1; s_rd = 5'd4; s_wd = 32'h45;
        tick();
        s_valid = 1'b0;
        tick(); #1;
        chk("sc_pending4_cleared", pending, 0);

        // x0 secondary result, drained under a primary write to x0.
        s_valid = 1'b1; s_rd = 5'd0; s_wd = 32'h99;
        tick();
        s_valid = 1'b0; #1;
        chk("x0_cnt", fifo_cnt, 1);
        chk("x0_rf_we", rf_we, 0);
        chk("x0_rf_a3", rf_a3, 0);
        chk("x0_pending", pending, 0);
        tick(); #1;
        chk("x0_cnt_after", fifo_cnt, 0);
        s_valid = 1'b1; s_rd = 5'd6; s_wd = 32'h66;
        tick();
        s_valid = 1'b0; p_we = 1'b1; p_rd = 5'd0; p_wd = 32'hBAD; #1;
        chk("px0_nonblock_rf_we", rf_we, 1);
        chk("px0_nonblock_rf_a3", rf_a3, 6);
        chk("px0_nonblock_rf_wd", rf_wd, 32'h66);
        tick();
        p_we = 1'b0; #1;
        chk("px0_cnt_after", fifo_cnt, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
